// File: rtl/seg_mux_display_n_if.sv
// -----------------------------------------------------------------------------
// seg_mux_display_n_if
//   Bundle between the application side (glyph writer) and the multiplexed
//   7-segment display driver.
//
//   Application -> driver:
//     seg_data   [5*NUM_DIGITS] glyph codes, digit k in bits [5k+4:5k]
//     dp_data    [NUM_DIGITS]   decimal point per digit, 1 = on
//     blink_mask [NUM_DIGITS]   1 = digit blinks
//     brightness [BRIGHT_W]     PWM duty level, 0 = dimmest, all-ones = full
//     load                      capture seg_data/dp_data/blink_mask
//   Driver -> board pins (observed by the application/bench):
//     seg [7] cathodes {g,f,e,d,c,b,a}, dp, an [NUM_DIGITS], frame_done
//
//   Modports: master = application side, slave = display driver.
// -----------------------------------------------------------------------------
interface seg_mux_display_n_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 4
);
  logic [5*NUM_DIGITS-1:0] seg_data;
  logic [NUM_DIGITS-1:0]   dp_data;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [BRIGHT_W-1:0]     brightness;
  logic                    load;

  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output seg_data, dp_data, blink_mask, brightness, load,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  seg_data, dp_data, blink_mask, brightness, load,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg_mux_display_n.sv
// -----------------------------------------------------------------------------
// seg_mux_display_n
//   N-digit multiplexed 7-segment display driver with PWM brightness,
//   per-digit blink and tear-free double-buffered glyph loading.
//
//   Each digit owns a slot of 2^SLOT_BITS cycles; slot s drives digit
//   NUM_DIGITS-1-s so the leftmost digit is scanned first. A frame is
//   NUM_DIGITS slots. New glyph data is staged on load and promoted to the
//   active set only on the last cycle of a frame, so a frame is never torn.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    seg_mux_display_n_if.slave (glyph inputs, pin outputs)
//
//   Parameters:
//     NUM_DIGITS     1..8 digits
//     SLOT_BITS      slot length exponent
//     BRIGHT_W       brightness width, <= SLOT_BITS
//     BLINK_FRAMES   frames per blink half-period, >= 1
//     AN_ACTIVE_LOW  1 = anode enabled when 0
//     SEG_ACTIVE_LOW 1 = segment/dp lit when 0
//   The interface instance must be built with the same NUM_DIGITS/BRIGHT_W.
// -----------------------------------------------------------------------------
module seg_mux_display_n #(
  parameter int NUM_DIGITS     = 4,
  parameter int SLOT_BITS      = 15,
  parameter int BRIGHT_W       = 4,
  parameter int BLINK_FRAMES   = 64,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  seg_mux_display_n_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] LAST_FRAME = FRM_W'(BLINK_FRAMES - 1);

  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);

  // Pin levels for "nothing driven"; also the reset state of the outputs.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_INV}};
  localparam logic [6:0]            SEG_OFF = {7{SEG_INV}};

  localparam logic [4:0] GLYPH_BLANK = 5'd31;

  // ---------------------------------------------------------------------------
  // Glyph decoder, active-low {g,f,e,d,c,b,a}. Unused codes render blank.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] f_decode(input logic [4:0] code);
    logic [6:0] pat;
    case (code)
      5'd0:    pat = 7'h40;
      5'd1:    pat = 7'h79;
      5'd2:    pat = 7'h24;
      5'd3:    pat = 7'h30;
      5'd4:    pat = 7'h19;
      5'd5:    pat = 7'h12;
      5'd6:    pat = 7'h02;
      5'd7:    pat = 7'h78;
      5'd8:    pat = 7'h00;
      5'd9:    pat = 7'h10;
      5'd10:   pat = 7'h3F;  // '-'
      5'd11:   pat = 7'h06;  // E
      5'd12:   pat = 7'h2F;  // r
      5'd13:   pat = 7'h47;  // L
      5'd14:   pat = 7'h09;  // H
      5'd15:   pat = 7'h41;  // U
      5'd16:   pat = 7'h0C;  // P
      5'd17:   pat = 7'h23;  // o
      5'd18:   pat = 7'h03;  // b
      5'd19:   pat = 7'h21;  // d
      5'd20:   pat = 7'h2B;  // n
      5'd21:   pat = 7'h71;  // J
      5'd22:   pat = 7'h11;  // y
      5'd30:   pat = 7'h0B;  // h
      default: pat = 7'h7F;  // blank: 23..29 and 31
    endcase
    return pat;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SLOT_BITS-1:0]    r_slot_cnt;
  logic [IDX_W-1:0]        r_slot_idx;
  logic [FRM_W-1:0]        r_frame_cnt;
  logic                    r_blink_hidden;

  logic [5*NUM_DIGITS-1:0] r_stg_glyph;
  logic [NUM_DIGITS-1:0]   r_stg_dp;
  logic [NUM_DIGITS-1:0]   r_stg_blink;
  logic                    r_pending;

  logic [5*NUM_DIGITS-1:0] r_act_glyph;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blink;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_done;

  // ---------------------------------------------------------------------------
  // Scan position and gating
  // ---------------------------------------------------------------------------
  logic                  w_slot_last;
  logic                  w_boundary;
  logic [IDX_W-1:0]      w_digit;
  logic [4:0]            w_glyph;
  logic                  w_dp_bit;
  logic                  w_blink_bit;
  logic                  w_pwm_on;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_an_on;
  logic [6:0]            w_seg_lit;
  logic                  w_dp_lit;

  assign w_slot_last = (r_slot_cnt == {SLOT_BITS{1'b1}});
  assign w_boundary  = w_slot_last && (r_slot_idx == LAST_IDX);

  // Leftmost digit first: slot 0 maps to digit NUM_DIGITS-1.
  assign w_digit = LAST_IDX - r_slot_idx;

  // PWM compares the top BRIGHT_W bits of the slot counter, so all-ones
  // brightness keeps the anode on for the whole slot.
  assign w_pwm_on = (r_slot_cnt[SLOT_BITS-1 -: BRIGHT_W] <= bus.brightness);

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_glyph     = GLYPH_BLANK;
    w_dp_bit    = 1'b0;
    w_blink_bit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_digit == IDX_W'(k)) begin
        w_glyph     = r_act_glyph[5*k +: 5];
        w_dp_bit    = r_act_dp[k];
        w_blink_bit = r_act_blink[k];
      end
    end
  end

  assign w_lit = w_pwm_on && !(r_blink_hidden && w_blink_bit);

  // Anode one-hot (active-high internally); all off when gated.
  always_comb begin
    w_an_on = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_lit && (w_digit == IDX_W'(k))) begin
        w_an_on[k] = 1'b1;
      end
    end
  end

  // Segments and dp forced unlit whenever the anode is gated off.
  assign w_seg_lit = w_lit ? ~f_decode(w_glyph) : 7'h00;
  assign w_dp_lit  = w_lit && w_dp_bit;

  // ---------------------------------------------------------------------------
  // Slot / frame / blink counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_cnt     <= '0;
      r_slot_idx     <= '0;
      r_frame_cnt    <= '0;
      r_blink_hidden <= 1'b0;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
      if (w_slot_last) begin
        r_slot_idx <= (r_slot_idx == LAST_IDX) ? '0 : r_slot_idx + 1'b1;
      end
      if (w_boundary) begin
        if (r_frame_cnt == LAST_FRAME) begin
          r_frame_cnt    <= '0;
          r_blink_hidden <= !r_blink_hidden;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Double buffer: staging follows load, active follows staging only on the
  // frame boundary. A load on the boundary itself is forwarded straight into
  // the active set so it still lands in the very next frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stg_glyph <= {NUM_DIGITS{GLYPH_BLANK}};
      r_stg_dp    <= '0;
      r_stg_blink <= '0;
      r_pending   <= 1'b0;
      r_act_glyph <= {NUM_DIGITS{GLYPH_BLANK}};
      r_act_dp    <= '0;
      r_act_blink <= '0;
    end else begin
      if (bus.load) begin
        r_stg_glyph <= bus.seg_data;
        r_stg_dp    <= bus.dp_data;
        r_stg_blink <= bus.blink_mask;
      end

      if (w_boundary) begin
        r_pending <= 1'b0;
        if (bus.load) begin
          r_act_glyph <= bus.seg_data;
          r_act_dp    <= bus.dp_data;
          r_act_blink <= bus.blink_mask;
        end else if (r_pending) begin
          r_act_glyph <= r_stg_glyph;
          r_act_dp    <= r_stg_dp;
          r_act_blink <= r_stg_blink;
        end
      end else if (bus.load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: polarity applied last, one cycle behind the counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= SEG_INV;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_on ^ AN_OFF;
      r_seg        <= w_seg_lit ^ SEG_OFF;
      r_dp         <= w_dp_lit ^ SEG_INV;
      r_frame_done <= w_boundary;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_mux_display_n.sv
// -----------------------------------------------------------------------------
// tb_seg_mux_display_n
//   Two instances with identical stimulus: dut_lo uses active-low anodes and
//   segments, dut_hi active-high. NUM_DIGITS=4, SLOT_BITS=4 (16-cycle slots,
//   64-cycle frames), BRIGHT_W=2, BLINK_FRAMES=2.
//   Expected pin values for every cycle are pushed to a queue before the
//   clock edge and popped/compared just after it.
// -----------------------------------------------------------------------------
module tb_seg_mux_display_n;

  localparam int ND  = 4;
  localparam int SB  = 4;
  localparam int BW  = 2;
  localparam int BF  = 2;
  localparam int FRAME = ND * (1 << SB);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seg_mux_display_n_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus_lo ();
  seg_mux_display_n_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus_hi ();

  seg_mux_display_n #(
    .NUM_DIGITS(ND), .SLOT_BITS(SB), .BRIGHT_W(BW), .BLINK_FRAMES(BF),
    .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut_lo (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_lo)
  );

  seg_mux_display_n #(
    .NUM_DIGITS(ND), .SLOT_BITS(SB), .BRIGHT_W(BW), .BLINK_FRAMES(BF),
    .AN_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) dut_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_hi)
  );

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic          fd;
  } obs_t;

  typedef struct packed {
    obs_t lo;
    obs_t hi;
  } pair_t;

  pair_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Bench-side view of the display contents.
  logic [5*ND-1:0] act_seg, stg_seg;
  logic [ND-1:0]   act_dp, stg_dp, act_bl, stg_bl;
  logic            pend;
  int              frame_no;

  function automatic logic [6:0] dec(input logic [4:0] c);
    logic [6:0] p;
    case (c)
      5'd0:  p = 7'h40; 5'd1:  p = 7'h79; 5'd2:  p = 7'h24; 5'd3:  p = 7'h30;
      5'd4:  p = 7'h19; 5'd5:  p = 7'h12; 5'd6:  p = 7'h02; 5'd7:  p = 7'h78;
      5'd8:  p = 7'h00; 5'd9:  p = 7'h10; 5'd10: p = 7'h3F; 5'd11: p = 7'h06;
      5'd12: p = 7'h2F; 5'd13: p = 7'h47; 5'd14: p = 7'h09; 5'd15: p = 7'h41;
      5'd16: p = 7'h0C; 5'd17: p = 7'h23; 5'd18: p = 7'h03; 5'd19: p = 7'h21;
      5'd20: p = 7'h2B; 5'd21: p = 7'h71; 5'd22: p = 7'h11; 5'd30: p = 7'h0B;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  // Expected pins after the edge that ends frame cycle c.
  function automatic pair_t expect_at(input int c, input logic [BW-1:0] br);
    pair_t r;
    int    cnt = c % (1 << SB);
    int    d   = ND - 1 - c / (1 << SB);
    logic  hidden = ((frame_no / BF) % 2) == 1;
    logic  on = ((cnt >> (SB - BW)) <= int'(br)) && !(hidden && act_bl[d]);
    r.lo.an  = '1;
    r.lo.seg = 7'h7F;
    r.lo.dp  = 1'b1;
    r.lo.fd  = (c == FRAME - 1);
    if (on) begin
      r.lo.an[d] = 1'b0;
      r.lo.seg   = dec(act_seg[5*d +: 5]);
      r.lo.dp    = !act_dp[d];
    end
    r.hi.an  = ~r.lo.an;
    r.hi.seg = ~r.lo.seg;
    r.hi.dp  = ~r.lo.dp;
    r.hi.fd  = r.lo.fd;
    return r;
  endfunction

  function automatic pair_t reset_expect();
    pair_t r;
    r.lo = '{an: '1, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
    r.hi = '{an: '0, seg: 7'h00, dp: 1'b0, fd: 1'b0};
    return r;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed an=%b seg=%h dp=%b fd=%b, expected an=%b seg=%h dp=%b fd=%b",
             tag, got.an, got.seg, got.dp, got.fd, exp.an, exp.seg, exp.dp, exp.fd);
    end
  endtask

  task automatic compare_pop(input string tag);
    pair_t p;
    obs_t  lo_got, hi_got;
    p      = exp_q.pop_front();
    lo_got = {bus_lo.an, bus_lo.seg, bus_lo.dp, bus_lo.frame_done};
    hi_got = {bus_hi.an, bus_hi.seg, bus_hi.dp, bus_hi.frame_done};
    check({tag, " lo"}, lo_got, p.lo);
    check({tag, " hi"}, hi_got, p.hi);
  endtask

  task automatic model_reset();
    act_seg  = {ND{5'd31}};
    stg_seg  = {ND{5'd31}};
    act_dp   = '0; stg_dp = '0;
    act_bl   = '0; stg_bl = '0;
    pend     = 1'b0;
    frame_no = 0;
  endtask

  // Runs n cycles from the start of a frame; optionally pulses load in cycle
  // ld_cyc (ld_cyc = FRAME-1 is the boundary cycle itself).
  task automatic run_frame(input int n, input int ld_cyc, input logic [5*ND-1:0] ld_seg,
                           input logic [ND-1:0] ld_dp, input logic [ND-1:0] ld_bl,
                           input logic [BW-1:0] br);
    bus_lo.brightness = br;
    bus_hi.brightness = br;
    for (int c = 0; c < n; c++) begin
      if (c == ld_cyc) begin
        bus_lo.seg_data = ld_seg; bus_lo.dp_data = ld_dp; bus_lo.blink_mask = ld_bl;
        bus_hi.seg_data = ld_seg; bus_hi.dp_data = ld_dp; bus_hi.blink_mask = ld_bl;
        bus_lo.load = 1'b1;
        bus_hi.load = 1'b1;
        stg_seg = ld_seg; stg_dp = ld_dp; stg_bl = ld_bl;
        pend = 1'b1;
      end
      exp_q.push_back(expect_at(c, br));
      @(posedge clk);
      #1;
      bus_lo.load = 1'b0;
      bus_hi.load = 1'b0;
      compare_pop($sformatf("f%0d c%0d", frame_no, c));
      if (c == FRAME - 1) begin
        if (pend) begin
          act_seg = stg_seg; act_dp = stg_dp; act_bl = stg_bl;
          pend = 1'b0;
        end
        frame_no++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_lo.seg_data = '0; bus_lo.dp_data = '0; bus_lo.blink_mask = '0;
    bus_lo.brightness = '1; bus_lo.load = 1'b0;
    bus_hi.seg_data = '0; bus_hi.dp_data = '0; bus_hi.blink_mask = '0;
    bus_hi.brightness = '1; bus_hi.load = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(reset_expect());
    compare_pop("reset");
    @(negedge clk);
    reset = 1'b0;

    // Frame 0: nothing loaded yet -> scan runs with blank glyphs.
    run_frame(FRAME, 10, {5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0000, 2'd3);
    // Frame 1: 30,24,79,40; mid-frame load of digit2=8 must not tear.
    run_frame(FRAME, 20, {5'd3, 5'd8, 5'd1, 5'd0}, 4'b0000, 4'b0000, 2'd3);
    // Frame 2: digit2 now 00; load on the boundary cycle (blank code 23,
    // dp on digit2, digit0 blinks).
    run_frame(FRAME, FRAME - 1, {5'd3, 5'd8, 5'd23, 5'd0}, 4'b0100, 4'b0001, 2'd3);
    // Frame 3: hidden blink phase -> digit0 dark.
    run_frame(FRAME, -1, '0, '0, '0, 2'd3);
    // Frames 4/5: visible phase, PWM at levels 0 and 2; codes 24..27 staged.
    run_frame(FRAME, -1, '0, '0, '0, 2'd0);
    run_frame(FRAME, 30, {5'd24, 5'd25, 5'd26, 5'd27}, 4'b0000, 4'b0001, 2'd2);
    // Frame 6: codes 24..27 blank; stage y/h glyphs with dp on digit0.
    run_frame(FRAME, 40, {5'd28, 5'd29, 5'd22, 5'd30}, 4'b0001, 4'b0001, 2'd2);
    // Frame 7 hidden (digit0 dark), frame 8 visible (digit0 'h' with dp).
    run_frame(FRAME, -1, '0, '0, '0, 2'd3);
    run_frame(FRAME, -1, '0, '0, '0, 2'd3);

    // Stage data, then reset mid-slot before the boundary.
    run_frame(37, 10, {5'd1, 5'd1, 5'd1, 5'd1}, 4'b1111, 4'b0000, 2'd3);
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(reset_expect());
    compare_pop("reset mid-slot");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(reset_expect());
    compare_pop("reset held");
    @(negedge clk);
    reset = 1'b0;

    // Staged data was lost: blank frame, then the new load shows.
    run_frame(FRAME, 5, {5'd4, 5'd5, 5'd6, 5'd7}, 4'b1000, 4'b0000, 2'd3);
    run_frame(FRAME, -1, '0, '0, '0, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
